// File: rtl/x3q16_pkg.sv
// x3q16 shared definitions: widths, ALU mode encodings, operand bundle.
// Imported by the execute stage and the ALU.
`timescale 1ns/1ps
package x3q16_pkg;

    localparam int X3Q16_DATA_W = 16;
    localparam int X3Q16_MODE_W = 3;
    localparam int X3Q16_TAG_W  = 3;

    localparam logic [X3Q16_MODE_W-1:0] MODE_ADD = 3'd0;
    localparam logic [X3Q16_MODE_W-1:0] MODE_SUB = 3'd1;
    localparam logic [X3Q16_MODE_W-1:0] MODE_AND = 3'd2;
    localparam logic [X3Q16_MODE_W-1:0] MODE_OR  = 3'd3;
    localparam logic [X3Q16_MODE_W-1:0] MODE_XOR = 3'd4;
    localparam logic [X3Q16_MODE_W-1:0] MODE_SHL = 3'd5;
    localparam logic [X3Q16_MODE_W-1:0] MODE_SHR = 3'd6;
    localparam logic [X3Q16_MODE_W-1:0] MODE_SRA = 3'd7;

    typedef struct packed {
        logic [X3Q16_MODE_W-1:0] mode;
        logic [X3Q16_DATA_W-1:0] a;
        logic [X3Q16_DATA_W-1:0] b;
    } x3q16_op_t;

endpackage

// File: rtl/x3q16alu.sv
// x3q16alu: combinational 16-bit ALU.
// Ports: mode/a/b in; result, ef (a==b), gaf (a>b unsigned) out.
`timescale 1ns/1ps
module x3q16alu
    import x3q16_pkg::*;
(
    input  logic [X3Q16_MODE_W-1:0] mode,
    input  logic [X3Q16_DATA_W-1:0] a,
    input  logic [X3Q16_DATA_W-1:0] b,
    output logic [X3Q16_DATA_W-1:0] result,
    output logic                    ef,
    output logic                    gaf
);

    logic [3:0] shamt;

    assign shamt = b[3:0];

    always_comb begin
        result = '0;
        unique case (mode)
            MODE_ADD: result = a + b;
            MODE_SUB: result = a - b;
            MODE_AND: result = a & b;
            MODE_OR:  result = a | b;
            MODE_XOR: result = a ^ b;
            MODE_SHL: result = a << shamt;
            MODE_SHR: result = a >> shamt;
            MODE_SRA: result = $signed(a) >>> shamt;
            default:  result = '0;
        endcase
    end

    // Flags compare the operands, not the result.
    assign ef  = (a == b);
    assign gaf = (a > b);

endmodule

// File: rtl/x3q16_exec_stage.sv
// x3q16 execute stage: S1 operand reg -> x3q16alu -> S2 result reg,
// valid/ready on both sides, plus retired-flags register for branches.
// Ports: clk, rst (async high), flush; in_* handshake + op bundle;
// out_* handshake + result/flags/tag; flags_ef/gaf; busy.
// Optional: define X3Q16_EXEC_OPCNT_EN to add op_count[15:0]
// (output handshakes, wraps, cleared only by rst).
`timescale 1ns/1ps
module x3q16_exec_stage
    import x3q16_pkg::*;
#(
    parameter int TAG_W  = X3Q16_TAG_W,
    parameter int DATA_W = X3Q16_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ef,
    output logic              out_gaf,
    output logic [TAG_W-1:0]  out_tag,
    output logic              flags_ef,
    output logic              flags_gaf,
    output logic              busy
`ifdef X3Q16_EXEC_OPCNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    x3q16_op_t         s1_op_q, s1_op_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s1_valid_q, s1_valid_d;

    logic [DATA_W-1:0] s2_result_q, s2_result_d;
    logic              s2_ef_q, s2_ef_d;
    logic              s2_gaf_q, s2_gaf_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic              s2_valid_q, s2_valid_d;

    logic              flags_ef_q, flags_ef_d;
    logic              flags_gaf_q, flags_gaf_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ef;
    logic              alu_gaf;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              s2_load;
    logic              handoff;

    x3q16alu u_alu (
        .mode   (s1_op_q.mode),
        .a      (s1_op_q.a),
        .b      (s1_op_q.b),
        .result (alu_result),
        .ef     (alu_ef),
        .gaf    (alu_gaf)
    );

    // Flush overrides every handshake: nothing enters, nothing retires.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !flush;
        accept   = in_valid && in_ready;
        s2_load  = s1_valid_q && s2_adv && !flush;
        handoff  = s2_valid_q && out_ready && !flush;
    end

    always_comb begin
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s1_valid_d  = s1_valid_q;
        s2_result_d = s2_result_q;
        s2_ef_d     = s2_ef_q;
        s2_gaf_d    = s2_gaf_q;
        s2_tag_d    = s2_tag_q;
        s2_valid_d  = s2_valid_q;
        flags_ef_d  = flags_ef_q;
        flags_gaf_d = flags_gaf_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_op_d.mode = in_mode;
                s1_op_d.a    = in_a;
                s1_op_d.b    = in_b;
                s1_tag_d     = in_tag;
                s1_valid_d   = 1'b1;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end

            if (s2_load) begin
                s2_result_d = alu_result;
                s2_ef_d     = alu_ef;
                s2_gaf_d    = alu_gaf;
                s2_tag_d    = s1_tag_q;
                s2_valid_d  = 1'b1;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end

            if (handoff) begin
                flags_ef_d  = s2_ef_q;
                flags_gaf_d = s2_gaf_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            s1_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ef_q     <= 1'b0;
            s2_gaf_q    <= 1'b0;
            s2_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            flags_ef_q  <= 1'b0;
            flags_gaf_q <= 1'b0;
        end else begin
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_valid_q  <= s1_valid_d;
            s2_result_q <= s2_result_d;
            s2_ef_q     <= s2_ef_d;
            s2_gaf_q    <= s2_gaf_d;
            s2_tag_q    <= s2_tag_d;
            s2_valid_q  <= s2_valid_d;
            flags_ef_q  <= flags_ef_d;
            flags_gaf_q <= flags_gaf_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_ef     = s2_ef_q;
    assign out_gaf    = s2_gaf_q;
    assign out_tag    = s2_tag_q;
    assign flags_ef   = flags_ef_q;
    assign flags_gaf  = flags_gaf_q;
    assign busy       = s1_valid_q || s2_valid_q;

`ifdef X3Q16_EXEC_OPCNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = handoff ? op_count_q + 16'd1 : op_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= 16'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_x3q16_exec_stage.sv
// Bench for x3q16_exec_stage: scoreboard of expected results,
// one task per scenario.
`timescale 1ns/1ps
module tb_x3q16_exec_stage;
    import x3q16_pkg::*;

    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_mode = '0;
    logic [15:0]   in_a = '0;
    logic [15:0]   in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_result;
    logic          out_ef;
    logic          out_gaf;
    logic [TW-1:0] out_tag;
    logic          flags_ef;
    logic          flags_gaf;
    logic          busy;
`ifdef X3Q16_EXEC_OPCNT_EN
    logic [15:0]   op_count;
`endif

    x3q16_exec_stage #(.TAG_W(TW), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ef     (out_ef),
        .out_gaf    (out_gaf),
        .out_tag    (out_tag),
        .flags_ef   (flags_ef),
        .flags_gaf  (flags_gaf),
        .busy       (busy)
`ifdef X3Q16_EXEC_OPCNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   res;
        logic          ef;
        logic          gaf;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_hand = 0;
    logic        exp_ef = 1'b0;
    logic        exp_gaf = 1'b0;
    logic        chk_lat = 1'b0;
    logic        hold = 1'b0;
    logic [20:0] hold_v = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] m,
                                   input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic [TW-1:0] t,
                                   input int c);
        exp_t       e;
        logic [3:0] s;
        s = b[3:0];
        case (m)
            3'd0: e.res = a + b;
            3'd1: e.res = a + ~b + 16'd1;
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = a << s;
            3'd6: e.res = a >> s;
            default: e.res = (a >> s) | (a[15] ? ~(16'hFFFF >> s) : 16'h0000);
        endcase
        e.ef  = (a == b);
        e.gaf = (a > b);
        e.tag = t;
        e.acc = c;
        return e;
    endfunction

    // Scoreboard: push on accept, pop on handoff, both sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_ef  = 1'b0;
            exp_gaf = 1'b0;
            hold    = 1'b0;
            n_hand  = 0;
        end else if (flush) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            checks++;
            if (flags_ef !== exp_ef || flags_gaf !== exp_gaf) begin
                errors++;
                $display("FAIL flags: got ef=%b gaf=%b want ef=%b gaf=%b",
                         flags_ef, flags_gaf, exp_ef, exp_gaf);
            end
            if (hold) begin
                checks++;
                if ({out_valid, out_result, out_ef, out_gaf, out_tag} !== {1'b1, hold_v}) begin
                    errors++;
                    $display("FAIL stall_hold: got %b_%h want 1_%h", out_valid,
                             {out_result, out_ef, out_gaf, out_tag}, hold_v);
                end
            end
            hold   = out_valid && !out_ready;
            hold_v = {out_result, out_ef, out_gaf, out_tag};
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL handoff_unexpected: got tag %0d want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_result !== e.res || out_ef !== e.ef ||
                        out_gaf !== e.gaf || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL result: got %h ef%b gaf%b tag%0d want %h ef%b gaf%b tag%0d",
                                 out_result, out_ef, out_gaf, out_tag, e.res, e.ef, e.gaf, e.tag);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc - e.acc != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d want 2", cyc - e.acc);
                        end
                    end
                    exp_ef  = e.ef;
                    exp_gaf = e.gaf;
                    n_hand++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mode, in_a, in_b, in_tag, cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_op(input logic [2:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        checks++;
        if ({out_result, out_ef, out_gaf, out_tag} !== 21'd0) begin
            errors++;
            $display("FAIL reset_out: got %h want 0", {out_result, out_ef, out_gaf, out_tag});
        end
        checks++;
        if (flags_ef !== 1'b0 || flags_gaf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b%b want 00", flags_ef, flags_gaf);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef X3Q16_EXEC_OPCNT_EN
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_op_count: got %h want 0000", op_count);
        end
`endif
    endtask

    task automatic test_streaming();
        logic [15:0] va [8] = '{16'h1234, 16'h0003, 16'hF0F0, 16'hF0F0,
                                16'hAAAA, 16'h8001, 16'h8001, 16'h8001};
        logic [15:0] vb [8] = '{16'h0FED, 16'h0005, 16'h0FF0, 16'h0F0F,
                                16'hFFFF, 16'h0004, 16'h0004, 16'h0004};
        int h0;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        h0        = n_hand;
        for (int i = 0; i < 8; i++) begin
            put_op(3'(i), va[i], vb[i], 3'(i));
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready: op %0d got %b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk_lat = 1'b0;
        checks++;
        if (n_hand - h0 != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d left %0d want 8 left 0", n_hand - h0, sb.size());
        end
    endtask

    task automatic test_flags();
        logic [15:0] fa [2] = '{16'h0005, 16'h0009};
        logic [15:0] fb [2] = '{16'h0005, 16'h0003};
        logic        wef [2] = '{1'b1, 1'b0};
        logic        wgaf [2] = '{1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            put_op(MODE_SUB, fa[i], fb[i], 3'(i + 1));
            tick();
            in_valid = 1'b0;
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_ef !== wef[i] || out_gaf !== wgaf[i]) begin
                errors++;
                $display("FAIL flags_out %0d: got v%b ef%b gaf%b want v1 ef%b gaf%b",
                         i, out_valid, out_ef, out_gaf, wef[i], wgaf[i]);
            end
            tick();
            checks++;
            if (flags_ef !== wef[i] || flags_gaf !== wgaf[i]) begin
                errors++;
                $display("FAIL flags_ret %0d: got ef%b gaf%b want ef%b gaf%b",
                         i, flags_ef, flags_gaf, wef[i], wgaf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int t = 0;
        int h0;
        h0        = n_hand;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put_op(MODE_ADD, 16'(100 + t), 16'(t * 3), 3'(t));
            @(negedge clk);
            if (in_ready) begin
                acc++;
                t++;
            end
            tick();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepts: got %0d want 2", acc);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got rdy%b v%b busy%b want 0 1 1", in_ready, out_valid, busy);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (n_hand - h0 != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d left %0d want 2 left 0", n_hand - h0, sb.size());
        end
    endtask

    task automatic test_flush();
        logic ef0;
        logic gaf0;
        out_ready = 1'b0;
        put_op(MODE_XOR, 16'h0F0F, 16'h00FF, 3'd5);
        tick();
        put_op(MODE_AND, 16'h0001, 16'h0007, 3'd6);
        tick();
        ef0   = exp_ef;
        gaf0  = exp_gaf;
        flush = 1'b1;
        put_op(MODE_OR, 16'h1111, 16'h2222, 3'd7);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got busy%b v%b want 0 0", busy, out_valid);
        end
        checks++;
        if (flags_ef !== ef0 || flags_gaf !== gaf0) begin
            errors++;
            $display("FAIL flush_flags: got %b%b want %b%b", flags_ef, flags_gaf, ef0, gaf0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_out: got tag %0d want none", out_tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        put_op(MODE_ADD, 16'h0010, 16'h0001, 3'd3);
        tick();
        put_op(MODE_SUB, 16'h0020, 16'h0002, 3'd4);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: got v%b busy%b want 0 0", out_valid, busy);
        end
        checks++;
        if (flags_ef !== 1'b0 || flags_gaf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: got %b%b want 00", flags_ef, flags_gaf);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got rdy%b v%b want 1 0", in_ready, out_valid);
        end
    endtask

`ifdef X3Q16_EXEC_OPCNT_EN
    task automatic test_opcnt();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            put_op(3'(i), 16'(i), 16'(i * 7), 3'(i));
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (op_count !== 16'hFFFF || n_hand != 65535) begin
            errors++;
            $display("FAIL opcnt_full: got %h (%0d) want ffff", op_count, n_hand);
        end
        put_op(MODE_ADD, 16'h0001, 16'h0001, 3'd0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL opcnt_wrap: got %h want 0000", op_count);
        end
        out_ready = 1'b0;
        put_op(MODE_ADD, 16'h0002, 16'h0001, 3'd1);
        tick();
        put_op(MODE_ADD, 16'h0003, 16'h0001, 3'd2);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL opcnt_flush: got %h want 0000", op_count);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_flags();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef X3Q16_EXEC_OPCNT_EN
        test_opcnt();
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
